volts_sweep_ctrl: RTL and testbench

Sequencing controller for the DAC/ADC voltage sweep. It drives the 2-bit opcode of the 12-bit step counter (00 clear, 01 hold, 10 add step, 11 clear) and walks the counter from code 0 through Steps increments. At each point it triggers a DAC write, waits a fixed settle time, then collects NSamples ADC conversions and reports their sum. It sits between the top-level start/status logic and the counter, DAC SPI driver and ADC SPI driver.

---
 rtl/volts_sweep_ctrl.sv | 156 +++++++++++++++
 tb/tb_volts_sweep_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/volts_sweep_ctrl.sv
// Voltage sweep sequencer: steps the DAC code counter, settles, accumulates
// NSamples ADC conversions per point and reports each point's sum.
module volts_sweep_ctrl #(
  parameter int unsigned Width        = 12,
  parameter int unsigned Steps        = 5,
  parameter int unsigned SettleCycles = 1000,
  parameter int unsigned NSamples     = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic [1:0]         opc1_o,
  output logic               dac_start_o,
  input  logic               dac_done_i,
  output logic               adc_start_o,
  input  logic               adc_done_i,
  input  logic [Width-1:0]   adc_data_i,
  output logic [Width+3:0]   sum_o,
  output logic [3:0]         point_o,
  output logic               sum_valid_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned SumW = Width + 4;
  localparam int unsigned SetW = 16;
  localparam int unsigned SmpW = 5;
  localparam int unsigned PtW  = 4;

  localparam logic [1:0] OpcClear = 2'b00;
  localparam logic [1:0] OpcHold  = 2'b01;
  localparam logic [1:0] OpcStep  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, CLEAR, DAC_WR, SETTLE, ADC_CONV, REPORT, INC, DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        opc1_q, opc1_d;
  logic              dac_start_q, dac_start_d;
  logic              adc_start_q, adc_start_d;
  logic              sum_valid_q, sum_valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [SumW-1:0]   sum_q, sum_d;
  logic [PtW-1:0]    point_q, point_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [SmpW-1:0]   smp_q, smp_d;

  // Next state, datapath and registered-output decode from the next state
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    point_d     = point_q;
    settle_d    = settle_q;
    smp_d       = smp_q;
    adc_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = CLEAR;
          point_d = '0;
          sum_d   = '0;
          smp_d   = '0;
        end
      end
      CLEAR: state_d = DAC_WR;
      DAC_WR: begin
        // a done in the same cycle as our own start pulse is not a reply
        if (dac_done_i && !dac_start_q) begin
          settle_d = SetW'(SettleCycles - 1);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d     = ADC_CONV;
          adc_start_d = 1'b1;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      ADC_CONV: begin
        if (adc_done_i && !adc_start_q) begin
          sum_d = sum_q + SumW'(adc_data_i);
          smp_d = smp_q + SmpW'(1);
          if (smp_d == SmpW'(NSamples)) begin
            state_d = REPORT;
          end else begin
            adc_start_d = 1'b1;
          end
        end
      end
      REPORT: begin
        if (point_q == PtW'(Steps)) begin
          state_d = DONE;
        end else begin
          state_d = INC;
          point_d = point_q + PtW'(1);
          sum_d   = '0;
          smp_d   = '0;
        end
      end
      INC:     state_d = DAC_WR;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    opc1_d = OpcHold;
    if (state_d == CLEAR) opc1_d = OpcClear;
    if (state_d == INC)   opc1_d = OpcStep;
    dac_start_d = (state_d == DAC_WR) && (state_q != DAC_WR);
    sum_valid_d = (state_d == REPORT);
    done_d      = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      opc1_q      <= OpcHold;
      dac_start_q <= 1'b0;
      adc_start_q <= 1'b0;
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sum_q       <= '0;
      point_q     <= '0;
      settle_q    <= '0;
      smp_q       <= '0;
    end else begin
      state_q     <= state_d;
      opc1_q      <= opc1_d;
      dac_start_q <= dac_start_d;
      adc_start_q <= adc_start_d;
      sum_valid_q <= sum_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sum_q       <= sum_d;
      point_q     <= point_d;
      settle_q    <= settle_d;
      smp_q       <= smp_d;
    end
  end

  assign opc1_o      = opc1_q;
  assign dac_start_o = dac_start_q;
  assign adc_start_o = adc_start_q;
  assign sum_valid_o = sum_valid_q;
  assign done_o      = done_q;
  assign busy_o      = busy_q;
  assign sum_o       = sum_q;
  assign point_o     = point_q;

endmodule

// File: tb/tb_volts_sweep_ctrl.sv
// Directed bench: u0 default parameters, u1 with Steps=2, SettleCycles=1,
// NSamples=16 and a constant full-scale ADC; DAC/ADC reply 3 cycles after start.
module tb_volts_sweep_ctrl;

  localparam int unsigned CodeStep = 819;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        start     [2];
  logic [1:0]  opc       [2];
  logic        dac_start [2];
  logic        dac_done  [2];
  logic        adc_start [2];
  logic        adc_done  [2];
  logic [11:0] adc_data  [2];
  logic [15:0] sum       [2];
  logic [3:0]  point     [2];
  logic        sum_valid [2];
  logic        busy      [2];
  logic        done      [2];
  logic [11:0] cnt       [2];
  logic [2:0]  dsr       [2];
  logic [2:0]  asr       [2];
  logic        spur      [2];

  volts_sweep_ctrl u0 (
    .clk_i(clk), .rst_i(rst[0]), .start_i(start[0]), .opc1_o(opc[0]),
    .dac_start_o(dac_start[0]), .dac_done_i(dac_done[0]),
    .adc_start_o(adc_start[0]), .adc_done_i(adc_done[0]), .adc_data_i(adc_data[0]),
    .sum_o(sum[0]), .point_o(point[0]), .sum_valid_o(sum_valid[0]),
    .busy_o(busy[0]), .done_o(done[0])
  );

  volts_sweep_ctrl #(.Width(12), .Steps(2), .SettleCycles(1), .NSamples(16)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .start_i(start[1]), .opc1_o(opc[1]),
    .dac_start_o(dac_start[1]), .dac_done_i(dac_done[1]),
    .adc_start_o(adc_start[1]), .adc_done_i(adc_done[1]), .adc_data_i(adc_data[1]),
    .sum_o(sum[1]), .point_o(point[1]), .sum_valid_o(sum_valid[1]),
    .busy_o(busy[1]), .done_o(done[1])
  );

  // Step counter and fixed-latency DAC/ADC reply models
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        cnt[i] <= '0;
        dsr[i] <= '0;
        asr[i] <= '0;
      end else begin
        case (opc[i])
          2'b10:   cnt[i] <= cnt[i] + 12'(CodeStep);
          2'b01:   cnt[i] <= cnt[i];
          default: cnt[i] <= '0;
        endcase
        dsr[i] <= {dsr[i][1:0], dac_start[i]};
        asr[i] <= {asr[i][1:0], adc_start[i]};
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dac_done[i] = dsr[i][2] | spur[i];
      adc_done[i] = asr[i][2] | spur[i];
      adc_data[i] = (i == 1 || spur[i]) ? 12'hFFF : cnt[i];
    end
  end

  int cyc = 0;
  int rec_n  [2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int n00    [2] = '{0, 0};
  int n10    [2] = '{0, 0};
  int n_gap  [2] = '{0, 0};
  int t_dd   [2] = '{0, 0};
  bit wd     [2] = '{0, 0};
  bit wa     [2] = '{0, 0};
  int rec_pt  [2][64];
  int rec_sum [2][64];
  int gap     [2][64];

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (sum_valid[i] && rec_n[i] < 64) begin
        rec_pt[i][rec_n[i]]  = int'(point[i]);
        rec_sum[i][rec_n[i]] = int'(sum[i]);
        rec_n[i]++;
      end
      if (done[i]) n_done[i]++;
      if (opc[i] == 2'b00) n00[i]++;
      if (opc[i] == 2'b10) n10[i]++;
      if (dac_start[i]) wd[i] = 1'b1;
      else if (dac_done[i] && wd[i]) begin
        wd[i] = 1'b0; wa[i] = 1'b1; t_dd[i] = cyc;
      end
      if (adc_start[i] && wa[i] && n_gap[i] < 64) begin
        wa[i] = 1'b0;
        gap[i][n_gap[i]] = cyc - t_dd[i];
        n_gap[i]++;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ncyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int i, input int target, input int budget);
    int k = 0;
    while (n_done[i] < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("done_reached_u%0d", i), n_done[i], target);
  endtask

  task automatic pulse_start(input int i);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic check_sweep0(input string tag, input int base);
    chk({tag, "_npoints"}, rec_n[0] - base, 6);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("%s_pt%0d", tag, k), rec_pt[0][base + k], k);
      chk($sformatf("%s_sum%0d", tag, k), rec_sum[0][base + k], 4 * CodeStep * k);
    end
  endtask

  initial begin
    int base, b00, b10, g0, dn, k;
    rst   = '{1'b1, 1'b1};
    start = '{1'b0, 1'b0};
    spur  = '{1'b0, 1'b0};
    ncyc(3);
    chk("rst_opc", opc[0], 2'b01);
    chk("rst_busy", busy[0], 0);
    chk("rst_dac_start", dac_start[0], 0);
    chk("rst_adc_start", adc_start[0], 0);
    chk("rst_sum_valid", sum_valid[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_sum", sum[0], 0);
    chk("rst_point", point[0], 0);
    rst = '{1'b0, 1'b0};
    ncyc(2);

    // Full sweep with start held high, a spurious reply in SETTLE, a mid-sweep start pulse
    base = rec_n[0]; b00 = n00[0]; b10 = n10[0]; g0 = n_gap[0];
    start[0] = 1'b1;
    @(negedge clk);
    chk("clear_opc", opc[0], 2'b00);
    chk("clear_busy", busy[0], 1);
    @(negedge clk);
    chk("first_dac_start", dac_start[0], 1);
    chk("dac_wr_opc_hold", opc[0], 2'b01);
    ncyc(498);
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    ncyc(2);
    chk("spur_settle_sum", sum[0], 0);
    chk("spur_settle_adc_start", adc_start[0], 0);
    ncyc(1500);
    start[0] = 1'b0;
    ncyc(2000);
    chk("mid_sweep_busy", busy[0], 1);
    pulse_start(0);
    wait_done(0, 1, 12000);
    check_sweep0("sweep1", base);
    chk("opc_clear_count", n00[0] - b00, 1);
    chk("opc_step_count", n10[0] - b10, 5);
    chk("settle_gap_1000", gap[0][g0], 1001);
    ncyc(30);
    chk("idle_busy", busy[0], 0);
    chk("single_done", n_done[0], 1);
    chk("no_restart", rec_n[0] - base, 6);

    // Spurious replies in IDLE
    spur[0] = 1'b1;
    @(negedge clk);
    spur[0] = 1'b0;
    ncyc(3);
    chk("spur_idle_busy", busy[0], 0);
    chk("spur_idle_sum_held", sum[0], 4 * 4095);
    chk("spur_idle_no_report", rec_n[0] - base, 6);

    // Reset in SETTLE of point 2, then a clean sweep
    base = rec_n[0];
    pulse_start(0);
    k = 0;
    while (rec_n[0] < base + 2 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("reached_point1_report", rec_n[0] - base, 2);
    ncyc(200);
    chk("settle_p2_point", point[0], 2);
    chk("settle_p2_busy", busy[0], 1);
    dn = n_done[0];
    rst[0] = 1'b1;
    #1;
    chk("abort_busy", busy[0], 0);
    chk("abort_point", point[0], 0);
    chk("abort_sum", sum[0], 0);
    chk("abort_opc", opc[0], 2'b01);
    chk("abort_dac_start", dac_start[0], 0);
    chk("abort_adc_start", adc_start[0], 0);
    ncyc(3);
    rst[0] = 1'b0;
    ncyc(20);
    chk("abort_no_done", n_done[0], dn);
    chk("abort_no_report", rec_n[0] - base, 2);
    base = rec_n[0];
    pulse_start(0);
    wait_done(0, dn + 1, 12000);
    check_sweep0("sweep2", base);

    // Short settle, 16 full-scale samples per point
    base = rec_n[1]; g0 = n_gap[1];
    pulse_start(1);
    wait_done(1, 1, 3000);
    chk("u1_npoints", rec_n[1] - base, 3);
    for (int p = 0; p < 3; p++) begin
      chk($sformatf("u1_pt%0d", p), rec_pt[1][base + p], p);
      chk($sformatf("u1_sum%0d", p), rec_sum[1][base + p], 65520);
    end
    chk("settle_gap_1", gap[1][g0], 2);
    ncyc(5);
    chk("u1_idle_busy", busy[1], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
